// File: rtl/func_op_sequencer.sv
// Command sequencer for the register-file/ALU datapath: buffers 4-bit func codes and runs each through SETUP, EXEC and WB.
// Optional retired-command counter on op_count is built when FUNC_SEQ_PERF_CNT_EN is defined.
module func_op_sequencer #(
    parameter int FIFO_DEPTH  = 2,
    parameter int EXEC_CYCLES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_func,
    input  logic        dp_ready,
    input  logic        err_clr,
    output logic        Muxsel2,
    output logic        WE1,
    output logic        WE2,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic [15:0] op_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = $clog2(EXEC_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EXEC, S_WB} state_t;

    state_t          state_q, state_d;
    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [3:0]      cur_func_q, cur_func_d;
    logic [EW-1:0]   exec_cnt_q, exec_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
    logic            we1_q, we2_q, done_q;
    logic            ready_en_q;
    logic            full, empty, push, pop, timeout_hit, wb_next;

    function automatic logic dec_mux(input logic [3:0] f);
        return f != 4'b0100;
    endfunction

    function automatic logic dec_we1(input logic [3:0] f);
        case (f)
            4'b0000, 4'b0011, 4'b0100, 4'b1000,
            4'b1001, 4'b1010, 4'b1011, 4'b1101: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic dec_we2(input logic [3:0] f);
        return f == 4'b0110;
    endfunction

    // ready_en_q holds cmd_ready low until the first edge after reset release
    assign full      = count_q == CW'(FIFO_DEPTH);
    assign empty     = count_q == '0;
    assign cmd_ready = ready_en_q && !full;
    assign push      = cmd_valid && cmd_ready;
    assign wb_next   = state_d == S_WB;

    always_comb begin
        state_d     = state_q;
        cur_func_d  = cur_func_q;
        exec_cnt_d  = exec_cnt_q;
        to_cnt_d    = to_cnt_q;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    cur_func_d = mem_q[rd_ptr_q];
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                exec_cnt_d = '0;
                to_cnt_d   = '0;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                // exec_cnt saturates at the minimum; only then is dp_ready honoured
                if (exec_cnt_q >= EW'(EXEC_CYCLES - 1)) begin
                    if (dp_ready) begin
                        state_d = S_WB;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                        if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                            timeout_hit = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end
                end else begin
                    exec_cnt_d = exec_cnt_q + 1'b1;
                end
            end
            S_WB: begin
                if (!empty) begin
                    pop        = 1'b1;
                    cur_func_d = mem_q[rd_ptr_q];
                    state_d    = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_func;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cur_func_q <= '0;
            exec_cnt_q <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
            we1_q      <= 1'b0;
            we2_q      <= 1'b0;
            done_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_func_q <= cur_func_d;
            exec_cnt_q <= exec_cnt_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
            we1_q      <= wb_next && dec_we1(cur_func_q);
            we2_q      <= wb_next && dec_we2(cur_func_q);
            done_q     <= wb_next;
            ready_en_q <= 1'b1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifdef FUNC_SEQ_PERF_CNT_EN
    logic [15:0] op_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q <= '0;
        end else if (wb_next) begin
            op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign op_count = op_cnt_q;
`else
    assign op_count = 16'h0000;
`endif

    assign Muxsel2 = (state_q != S_IDLE) && dec_mux(cur_func_q);
    assign WE1     = we1_q;
    assign WE2     = we2_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_func_op_sequencer.sv
// Directed bench for func_op_sequencer: per-code decode table plus hand-written multi-cycle sequences.
module tb_func_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_func = 4'h0;
    logic        dp_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        cmd_ready, Muxsel2, WE1, WE2, done, busy, err;
    logic [15:0] op_count;

    func_op_sequencer #(.FIFO_DEPTH(2), .EXEC_CYCLES(2), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_func(cmd_func), .dp_ready(dp_ready), .err_clr(err_clr),
        .Muxsel2(Muxsel2), .WE1(WE1), .WE2(WE2), .done(done), .busy(busy),
        .err(err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int   nVec = 0;
    int   nErr = 0;
    int   cyc = 0;
    int   doneCyc[$];
    logic doneWe1[$];
    logic doneWe2[$];
    logic muxLog [0:4095];

    always @(posedge clk) cyc <= cyc + 1;

    // Edge index k is logged at the negedge following edge k
    always @(negedge clk) begin
        if (cyc < 4096) muxLog[cyc] = Muxsel2;
        if (done) begin
            doneCyc.push_back(cyc);
            doneWe1.push_back(WE1);
            doneWe2.push_back(WE2);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [3:0] func;
        logic       expMux;
        logic       expWe1;
        logic       expWe2;
    } vec_t;

    vec_t tbl [16];

    task automatic checkOutput(input string name, input logic act, input logic exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns one time unit after the edge on which the command was accepted
    task automatic applyStimulus(input logic [3:0] f, output int acceptCyc);
        bit ok = 0;
        cmd_valid = 1'b1;
        cmd_func  = f;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (cmd_ready) ok = 1;
            tick(1);
        end
        cmd_valid = 1'b0;
        acceptCyc = cyc;
        if (!ok) checkCount("accept wait", 0, 1);
    endtask

    task automatic waitIdle(input string name, input int maxCycles);
        for (int i = 0; i < maxCycles && busy; i++) tick(1);
        checkOutput(name, busy, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " cmd_ready"}, cmd_ready, 1'b0);
        checkOutput({tag, " Muxsel2"}, Muxsel2, 1'b0);
        checkOutput({tag, " WE1"}, WE1, 1'b0);
        checkOutput({tag, " WE2"}, WE2, 1'b0);
        checkOutput({tag, " done"}, done, 1'b0);
        checkOutput({tag, " busy"}, busy, 1'b0);
        checkOutput({tag, " err"}, err, 1'b0);
        checkCount({tag, " op_count"}, int'(op_count), 0);
    endtask

    function automatic int expOps(input int n);
`ifdef FUNC_SEQ_PERF_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    initial begin
        int acc, acc2, base;
        logic expMux [3];

        tbl[0]  = '{4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{4'b0001, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'b0010, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{4'b0011, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{4'b0101, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{4'b0110, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{4'b0111, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{4'b1000, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{4'b1001, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{4'b1010, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{4'b1011, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{4'b1100, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{4'b1101, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{4'b1110, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{4'b1111, 1'b1, 1'b0, 1'b0};

        // Reset state, then cmd_ready only after the first edge past release
        tick(3);
        checkAllZero("reset");
        rst_n = 1'b1;
        #1;
        checkOutput("cmd_ready before first edge", cmd_ready, 1'b0);
        tick(1);
        checkOutput("cmd_ready after release", cmd_ready, 1'b1);

        // Decode table: accept on E0, SETUP E1, EXEC E2-E3, WB E4
        dp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].func, acc);
            checkOutput($sformatf("tbl%0d busy E0", i), busy, 1'b1);
            tick(1);
            checkOutput($sformatf("tbl%0d mux SETUP", i), Muxsel2, tbl[i].expMux);
            tick(2);
            checkOutput($sformatf("tbl%0d mux EXEC", i), Muxsel2, tbl[i].expMux);
            checkOutput($sformatf("tbl%0d done EXEC", i), done, 1'b0);
            checkOutput($sformatf("tbl%0d WE1 EXEC", i), WE1, 1'b0);
            tick(1);
            checkOutput($sformatf("tbl%0d done WB", i), done, 1'b1);
            checkOutput($sformatf("tbl%0d WE1 WB", i), WE1, tbl[i].expWe1);
            checkOutput($sformatf("tbl%0d WE2 WB", i), WE2, tbl[i].expWe2);
            checkOutput($sformatf("tbl%0d mux WB", i), Muxsel2, tbl[i].expMux);
            checkCount($sformatf("tbl%0d op_count", i), int'(op_count), expOps(i + 1));
            tick(1);
            checkOutput($sformatf("tbl%0d done after", i), done, 1'b0);
            checkOutput($sformatf("tbl%0d WE1 after", i), WE1, 1'b0);
            checkOutput($sformatf("tbl%0d WE2 after", i), WE2, 1'b0);
            checkOutput($sformatf("tbl%0d busy after", i), busy, 1'b0);
            checkOutput($sformatf("tbl%0d mux IDLE", i), Muxsel2, 1'b0);
        end

        // Back-to-back 0110, 0100, 0001
        base = doneCyc.size();
        applyStimulus(4'b0110, acc);
        applyStimulus(4'b0100, acc2);
        applyStimulus(4'b0001, acc2);
        checkOutput("b2b cmd_ready full", cmd_ready, 1'b0);
        waitIdle("b2b idle", 40);
        checkCount("b2b done count", doneCyc.size() - base, 3);
        if (doneCyc.size() >= base + 3) begin
            expMux = '{1'b1, 1'b0, 1'b1};
            checkCount("b2b first latency", doneCyc[base] - acc, 4);
            checkCount("b2b spacing 1-2", doneCyc[base+1] - doneCyc[base], 4);
            checkCount("b2b spacing 2-3", doneCyc[base+2] - doneCyc[base+1], 4);
            checkOutput("b2b cmd0 WE1", doneWe1[base], 1'b0);
            checkOutput("b2b cmd0 WE2", doneWe2[base], 1'b1);
            checkOutput("b2b cmd1 WE1", doneWe1[base+1], 1'b1);
            checkOutput("b2b cmd1 WE2", doneWe2[base+1], 1'b0);
            checkOutput("b2b cmd2 WE1", doneWe1[base+2], 1'b0);
            checkOutput("b2b cmd2 WE2", doneWe2[base+2], 1'b0);
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < 4; k++)
                    checkOutput($sformatf("b2b cmd%0d mux k%0d", c, k),
                                muxLog[doneCyc[base+c] - k], expMux[c]);
        end

        // Timeout on 1101 with 0011 queued behind it
        dp_ready = 1'b0;
        base = doneCyc.size();
        applyStimulus(4'b1101, acc);
        applyStimulus(4'b0011, acc2);
        tick(16);
        checkOutput("timeout err before E18", err, 1'b0);
        tick(1);
        checkOutput("timeout err at E18", err, 1'b1);
        checkOutput("timeout no done", done, 1'b0);
        checkOutput("timeout no WE1", WE1, 1'b0);
        dp_ready = 1'b1;
        tick(4);
        checkOutput("queued after timeout done", done, 1'b1);
        checkOutput("queued after timeout WE1", WE1, 1'b1);
        waitIdle("timeout idle", 20);
        checkCount("timeout done count", doneCyc.size() - base, 1);
        if (doneCyc.size() > base) checkCount("queued done edge", doneCyc[base] - acc, 22);
        checkOutput("err sticky", err, 1'b1);

        // err_clr, then set-wins on a coincident timeout
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checkOutput("err cleared", err, 1'b0);
        dp_ready = 1'b0;
        base = doneCyc.size();
        applyStimulus(4'b0000, acc);
        tick(17);
        checkOutput("clr race err before", err, 1'b0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checkOutput("set wins over clear", err, 1'b1);
        dp_ready = 1'b1;
        waitIdle("clr race idle", 20);
        checkCount("clr race no done", doneCyc.size() - base, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;

        // dp_ready raised 5 cycles after the minimum
        dp_ready = 1'b0;
        applyStimulus(4'b1000, acc);
        tick(8);
        checkOutput("late dp no done yet", done, 1'b0);
        dp_ready = 1'b1;
        tick(1);
        checkOutput("late dp done", done, 1'b1);
        checkOutput("late dp WE1", WE1, 1'b1);
        checkOutput("late dp err", err, 1'b0);
        waitIdle("late dp idle", 10);

        // Reset during EXEC with one command queued
        dp_ready = 1'b0;
        applyStimulus(4'b0011, acc);
        applyStimulus(4'b0110, acc2);
        tick(2);
        rst_n = 1'b0;
        #1;
        checkAllZero("mid reset");
        base = doneCyc.size();
        #2;
        rst_n = 1'b1;
        dp_ready = 1'b1;
        tick(1);
        checkOutput("post reset cmd_ready", cmd_ready, 1'b1);
        tick(10);
        checkCount("post reset no done", doneCyc.size() - base, 0);
        checkOutput("post reset busy", busy, 1'b0);
        checkOutput("post reset cmd_ready idle", cmd_ready, 1'b1);

        // Three completions and one timeout since reset
        applyStimulus(4'b0011, acc);
        applyStimulus(4'b0110, acc);
        applyStimulus(4'b0001, acc);
        waitIdle("perf idle 1", 40);
        dp_ready = 1'b0;
        applyStimulus(4'b0000, acc);
        for (int i = 0; i < 40 && !err; i++) tick(1);
        checkOutput("perf timeout err", err, 1'b1);
        waitIdle("perf idle 2", 10);
        checkCount("perf op_count", int'(op_count), expOps(3));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/func_op_sequencer.md
Name: func_op_sequencer

Overview:
- Multi-cycle sequencer for the register-file/ALU datapath.
- Accepts 4-bit func commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues each command as SETUP -> EXEC -> WB: holds the datapath mux select through the operation and fires the register write enables as one-cycle pulses at writeback.
- Waits on datapath completion and aborts with a sticky error if the datapath times out.

Parameters:
- FIFO_DEPTH, 2, command FIFO entries; power of 2, >= 2.
- EXEC_CYCLES, 2, minimum cycles spent in EXEC; >= 1.
- TIMEOUT, 15, max cycles to wait for dp_ready after the EXEC minimum elapses; >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept.
- cmd_func  in  4  command code.
- dp_ready  in  1  datapath result ready; sampled in EXEC.
- err_clr  in  1  clears err.
- Muxsel2  out  1  datapath mux select.
- WE1  out  1  register 1 write-enable pulse.
- WE2  out  1  register 2 write-enable pulse.
- done  out  1  one-cycle pulse per completed command.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- err  out  1  sticky timeout flag.
- op_count  out  16  retired-command count (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): FIFO flushed, state IDLE, counters 0. All outputs 0, including cmd_ready. cmd_ready rises the first cycle after rst_n deasserts.
- Reset mid-operation abandons the current command and all queued commands. No WE pulse is issued for them.
- Decode of cur_func, fixed:
  - Muxsel2 = 1 for every func except 4'b0100.
  - WE1 set = {0000, 0011, 0100, 1000, 1001, 1010, 1011, 1101}.
  - WE2 set = {0110}.
  - All 16 codes are legal. Codes in neither WE set still run the full sequence and pulse done.
- FIFO:
  - cmd_ready = !full.
  - Push on cmd_valid && cmd_ready. No bypass: a command is visible to the FSM the cycle after the push.
  - Pop occurs on the same edge as the transition into SETUP.
  - Simultaneous push and pop is legal when not full. Count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, EXEC, WB.
  - IDLE: if FIFO non-empty, pop into cur_func and go to SETUP.
  - SETUP: 1 cycle, then EXEC. Clear exec_cnt and to_cnt.
  - EXEC: exec_cnt increments each cycle.
    - Once exec_cnt >= EXEC_CYCLES-1 and dp_ready = 1, go to WB.
    - After the minimum, each cycle with dp_ready = 0 increments to_cnt.
    - When to_cnt reaches TIMEOUT, set err and go to IDLE. No WB, no done, no WE.
  - WB: 1 cycle. Then go to SETUP (popping) if the FIFO is non-empty, else IDLE.
- Outputs:
  - Muxsel2 = decode(cur_func) in SETUP, EXEC and WB; 0 in IDLE.
  - WE1, WE2 and done are registered, high only during the WB cycle.
- Latency: with an idle FSM, empty FIFO and dp_ready held 1, a command accepted on edge E0 produces its WB cycle between edges E(2+EXEC_CYCLES) and E(3+EXEC_CYCLES).
- Back-to-back throughput: one command per EXEC_CYCLES+2 cycles.
- err: set on timeout, cleared by err_clr. Set wins over a simultaneous clear. err does not stall the FSM.
- busy is combinational from state and FIFO count.

Optional Feature:
- Macro: FUNC_SEQ_PERF_CNT_EN.
- Defined: op_count increments on every done pulse. It wraps 16'hFFFF -> 0, resets to 0, and is not incremented on timeout aborts.
- Undefined: op_count tied to 16'h0000 and no counter logic is synthesized. The port list is identical in both builds.

Test Plan:
- Reset release, push func 0011, dp_ready = 1, EXEC_CYCLES = 2 -> Muxsel2 = 1 from SETUP; WE1 = 1, WE2 = 0, done = 1 for exactly one cycle 4 edges after acceptance; busy drops the next cycle.
- Push 0110, then 0100, then 0001 back-to-back -> FIFO fills and cmd_ready drops at 2 queued. Pulses appear in order: WE2 only; WE1 only with Muxsel2 = 0 throughout; done only. The three WB cycles are spaced 4 cycles apart.
- Push 1101 with dp_ready = 0 for 20 cycles -> err sets when to_cnt reaches 15; no WE1 or done. Next queued command still executes. err_clr and a timeout in the same cycle -> err stays 1.
- dp_ready held 0, then raised 5 cycles after the minimum -> WB the cycle after dp_ready is sampled high; err stays 0.
- Assert rst_n = 0 during EXEC with 1 command queued -> all outputs 0 immediately. After release: no WE or done pulse, busy = 0, cmd_ready = 1.
- FUNC_SEQ_PERF_CNT_EN defined, 3 completions plus 1 timeout -> op_count = 3. Undefined -> op_count = 0 throughout.
